// File: rtl/axi_lite_master_if.sv
// AXI4-Lite channel bundle (AW/W/B/AR/R) between one initiator and one register slave.
interface axi_lite_master_if #(
    parameter int ADDR_BW = 12
);
    logic [ADDR_BW-1:0] awaddr;
    logic               awvalid;
    logic               awready;
    logic [31:0]        wdata;
    logic [3:0]         wstrb;
    logic               wvalid;
    logic               wready;
    logic [1:0]         bresp;
    logic               bvalid;
    logic               bready;
    logic [ADDR_BW-1:0] araddr;
    logic               arvalid;
    logic               arready;
    logic [31:0]        rdata;
    logic [1:0]         rresp;
    logic               rvalid;
    logic               rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI write or read out,
// one response back, with a saturating count of non-OKAY responses.
module axi_lite_master #(
    parameter int AXI_ADDR_BW_p = 12,
    parameter int ERR_CNT_BW_p  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic                     i_cmd_write,
    input  logic [AXI_ADDR_BW_p-1:0] i_cmd_addr,
    input  logic [31:0]              i_cmd_wdata,
    input  logic [3:0]               i_cmd_wstrb,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic                     o_rsp_write,
    output logic [31:0]              o_rsp_rdata,
    output logic [1:0]               o_rsp_resp,
    output logic [ERR_CNT_BW_p-1:0]  o_err_count,
    axi_lite_master_if.master        axi
);
    typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;

    localparam logic [ERR_CNT_BW_p-1:0] ERR_MAX = '1;

    state_t                   state_reg;
    logic                     cmd_ready_reg;
    logic [AXI_ADDR_BW_p-1:0] awaddr_reg;
    logic [AXI_ADDR_BW_p-1:0] araddr_reg;
    logic [31:0]              wdata_reg;
    logic [3:0]               wstrb_reg;
    logic                     awvalid_reg;
    logic                     wvalid_reg;
    logic                     bready_reg;
    logic                     arvalid_reg;
    logic                     rready_reg;
    logic                     rsp_valid_reg;
    logic                     rsp_write_reg;
    logic [31:0]              rsp_rdata_reg;
    logic [1:0]               rsp_resp_reg;
    logic [ERR_CNT_BW_p-1:0]  err_count_reg;

    logic       resp_hs;
    logic [1:0] resp_code;

    // Either B or R completing ends the transaction; only one can be live per state.
    always_comb begin
        resp_hs   = 1'b0;
        resp_code = 2'b00;
        if (state_reg == WR) begin
            resp_hs   = axi.bvalid && bready_reg;
            resp_code = axi.bresp;
        end else if (state_reg == RD) begin
            resp_hs   = axi.rvalid && rready_reg;
            resp_code = axi.rresp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cmd_ready_reg <= 1'b0;
            awaddr_reg    <= '0;
            araddr_reg    <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_write_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= '0;
            err_count_reg <= '0;
        end else begin
            if (resp_hs && resp_code != 2'b00 && err_count_reg != ERR_MAX)
                err_count_reg <= err_count_reg + ERR_CNT_BW_p'(1);

            case (state_reg)
                IDLE: begin
                    cmd_ready_reg <= 1'b1;
                    if (i_cmd_valid && cmd_ready_reg) begin
                        cmd_ready_reg <= 1'b0;
                        if (i_cmd_write) begin
                            awaddr_reg  <= i_cmd_addr;
                            wdata_reg   <= i_cmd_wdata;
                            wstrb_reg   <= i_cmd_wstrb;
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                            bready_reg  <= 1'b1;
                            state_reg   <= WR;
                        end else begin
                            araddr_reg  <= i_cmd_addr;
                            arvalid_reg <= 1'b1;
                            rready_reg  <= 1'b1;
                            state_reg   <= RD;
                        end
                    end
                end
                WR: begin
                    // AW and W retire independently; the response waits on B only.
                    if (awvalid_reg && axi.awready) awvalid_reg <= 1'b0;
                    if (wvalid_reg && axi.wready)   wvalid_reg  <= 1'b0;
                    if (resp_hs) begin
                        awvalid_reg   <= 1'b0;
                        wvalid_reg    <= 1'b0;
                        bready_reg    <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_write_reg <= 1'b1;
                        rsp_rdata_reg <= '0;
                        rsp_resp_reg  <= resp_code;
                        state_reg     <= RSP;
                    end
                end
                RD: begin
                    if (arvalid_reg && axi.arready) arvalid_reg <= 1'b0;
                    if (resp_hs) begin
                        arvalid_reg   <= 1'b0;
                        rready_reg    <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_write_reg <= 1'b0;
                        rsp_rdata_reg <= axi.rdata;
                        rsp_resp_reg  <= resp_code;
                        state_reg     <= RSP;
                    end
                end
                RSP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_cmd_ready = cmd_ready_reg;
    assign o_rsp_valid = rsp_valid_reg;
    assign o_rsp_write = rsp_write_reg;
    assign o_rsp_rdata = rsp_rdata_reg;
    assign o_rsp_resp  = rsp_resp_reg;
    assign o_err_count = err_count_reg;

    assign axi.awaddr  = awaddr_reg;
    assign axi.awvalid = awvalid_reg;
    assign axi.wdata   = wdata_reg;
    assign axi.wstrb   = wstrb_reg;
    assign axi.wvalid  = wvalid_reg;
    assign axi.bready  = bready_reg;
    assign axi.araddr  = araddr_reg;
    assign axi.arvalid = arvalid_reg;
    assign axi.rready  = rready_reg;
endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: stallable memory slave, vector table, randomized traffic
// against a byte-level memory model, and hand-written stall/backpressure/reset sequences.
module tb_axi_lite_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [11:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  err_count;

    axi_lite_master_if #(.ADDR_BW(12)) axi ();

    axi_lite_master #(.AXI_ADDR_BW_p(12), .ERR_CNT_BW_p(8)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_write(rsp_write),
        .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp), .o_err_count(err_count),
        .axi(axi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Address map of the test slave: 0x1xx SLVERR, 0x2xx DECERR, 0x3xx EXOKAY, rest OKAY memory.
    function automatic logic [1:0] region_resp(input logic [11:0] a);
        case (a[11:8])
            4'h1:    return 2'b10;
            4'h2:    return 2'b11;
            4'h3:    return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // ---------------- slave ----------------
    int aw_stall = 0, w_stall = 0, b_stall = 0, ar_stall = 0, r_stall = 0;
    logic [31:0] smem [0:1023];
    bit          got_aw, got_w, b_busy, r_busy;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic [11:0] s_waddr;
    logic [31:0] s_wd;
    logic [3:0]  s_ws;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [11:0] hs_awaddr, hs_araddr;
    logic [31:0] hs_wdata;
    logic [3:0]  hs_wstrb;

    initial begin
        for (int i = 0; i < 1024; i++) smem[i] = '0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rresp = 0; axi.rdata = 0;
        got_aw = 0; got_w = 0; b_busy = 0; r_busy = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        forever begin
            @(negedge clk);
            aw_hs = axi.awvalid && axi.awready; hs_awaddr = axi.awaddr;
            w_hs  = axi.wvalid && axi.wready;   hs_wdata = axi.wdata; hs_wstrb = axi.wstrb;
            b_hs  = axi.bvalid && axi.bready;
            ar_hs = axi.arvalid && axi.arready; hs_araddr = axi.araddr;
            r_hs  = axi.rvalid && axi.rready;
            @(posedge clk);
            #1;
            if (rst) begin
                axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
                axi.arready = 0; axi.rvalid = 0;
                got_aw = 0; got_w = 0; b_busy = 0; r_busy = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            end else begin
                if (b_hs) begin axi.bvalid = 0; b_busy = 0; got_aw = 0; got_w = 0; end
                if (aw_hs) begin got_aw = 1; s_waddr = hs_awaddr; end
                if (w_hs) begin got_w = 1; s_wd = hs_wdata; s_ws = hs_wstrb; end
                if (got_aw && got_w && !b_busy) begin
                    b_busy = 1; b_cnt = b_stall; s_bresp = region_resp(s_waddr);
                    if (s_bresp == 2'b00)
                        for (int b = 0; b < 4; b++)
                            if (s_ws[b]) smem[s_waddr[11:2]][8*b +: 8] = s_wd[8*b +: 8];
                end
                if (b_busy && !axi.bvalid) begin
                    if (b_cnt == 0) begin axi.bvalid = 1; axi.bresp = s_bresp; end
                    else b_cnt--;
                end
                if (r_hs) begin axi.rvalid = 0; r_busy = 0; end
                if (ar_hs) begin
                    r_busy = 1; r_cnt = r_stall; s_rresp = region_resp(hs_araddr);
                    s_rdata = (s_rresp == 2'b00) ? smem[hs_araddr[11:2]] : 32'hdeaddead;
                end
                if (r_busy && !axi.rvalid) begin
                    if (r_cnt == 0) begin axi.rvalid = 1; axi.rresp = s_rresp; axi.rdata = s_rdata; end
                    else r_cnt--;
                end
                if (axi.awvalid && !got_aw) begin axi.awready = (aw_cnt >= aw_stall); aw_cnt++; end
                else begin axi.awready = 0; aw_cnt = 0; end
                if (axi.wvalid && !got_w) begin axi.wready = (w_cnt >= w_stall); w_cnt++; end
                else begin axi.wready = 0; w_cnt = 0; end
                if (axi.arvalid && !r_busy) begin axi.arready = (ar_cnt >= ar_stall); ar_cnt++; end
                else begin axi.arready = 0; ar_cnt = 0; end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] mm [0:4095];
    int         err_model = 0;

    task automatic model_step(input bit wr, input logic [11:0] a, input logic [31:0] wd,
                              input logic [3:0] ws, output logic [1:0] e_resp,
                              output logic [31:0] e_rdata);
        int base;
        base    = int'(a) & ~3;
        e_resp  = region_resp(a);
        e_rdata = 32'h0;
        if (wr) begin
            if (e_resp == 2'b00)
                for (int b = 0; b < 4; b++)
                    if (ws[b]) mm[base + b] = wd[8*b +: 8];
        end else if (e_resp == 2'b00) begin
            e_rdata = {mm[base + 3], mm[base + 2], mm[base + 1], mm[base]};
        end else begin
            e_rdata = 32'hdeaddead;
        end
        if (e_resp != 2'b00 && err_model < 255) err_model++;
    endtask

    // ---------------- transaction driver ----------------
    logic [1:0]  t_resp;
    logic [31:0] t_rdata;
    logic        t_write;
    logic [7:0]  t_err;
    int          t_lat, t_aw_low, t_w_cyc, t_addr_bad, t_hold_bad;
    bit          t_timeout;

    task automatic do_txn(input bit wr, input logic [11:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input int hold, input bit spam);
        int n;
        t_timeout = 0; t_lat = 0; t_aw_low = 0; t_w_cyc = 0; t_addr_bad = 0; t_hold_bad = 0;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
            t_timeout = 1;
            return;
        end
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_wstrb = ws;
        @(posedge clk);
        #1 cmd_valid = 0;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            t_lat++;
            if (axi.awvalid && !axi.awready) t_aw_low++;
            if (axi.wvalid) t_w_cyc++;
            if (axi.awvalid && axi.awaddr !== a) t_addr_bad++;
            if (axi.wvalid && (axi.wdata !== wd || axi.wstrb !== ws)) t_addr_bad++;
            if (axi.arvalid && axi.araddr !== a) t_addr_bad++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) begin
            check("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
            t_timeout = 1;
            return;
        end
        t_resp = rsp_resp; t_rdata = rsp_rdata; t_write = rsp_write; t_err = err_count;
        for (int h = 0; h < hold; h++) begin
            if (spam) begin
                cmd_valid = 1; cmd_write = ~wr; cmd_addr = a ^ 12'h040;
            end
            @(negedge clk);
            if (!rsp_valid || rsp_resp !== t_resp || rsp_rdata !== t_rdata ||
                rsp_write !== t_write || cmd_ready || axi.awvalid || axi.arvalid)
                t_hold_bad++;
        end
        cmd_valid = 0;
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        $display("txn %s addr=%h wdata=%h strb=%h resp=%0d rdata=%h err=%0d lat=%0d",
                 wr ? "WR" : "RD", a, wd, ws, t_resp, t_rdata, t_err, t_lat);
    endtask

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
        for (int i = 0; i < 4096; i++) mm[i] = '0;

        vecs[0]  = '{1'b1, 12'h004, 32'h12345678, 4'hF, 2'd0, 32'h00000000, 8'd0};
        vecs[1]  = '{1'b0, 12'h004, 32'h00000000, 4'h0, 2'd0, 32'h12345678, 8'd0};
        vecs[2]  = '{1'b0, 12'h100, 32'h00000000, 4'h0, 2'd2, 32'hdeaddead, 8'd1};
        vecs[3]  = '{1'b1, 12'h008, 32'hAABBCCDD, 4'h5, 2'd0, 32'h00000000, 8'd1};
        vecs[4]  = '{1'b0, 12'h008, 32'h00000000, 4'h0, 2'd0, 32'h00BB00DD, 8'd1};
        vecs[5]  = '{1'b1, 12'h00C, 32'h11223344, 4'hA, 2'd0, 32'h00000000, 8'd1};
        vecs[6]  = '{1'b0, 12'h00C, 32'h00000000, 4'h0, 2'd0, 32'h11003300, 8'd1};
        vecs[7]  = '{1'b1, 12'h210, 32'h55555555, 4'hF, 2'd3, 32'h00000000, 8'd2};
        vecs[8]  = '{1'b0, 12'h210, 32'h00000000, 4'h0, 2'd3, 32'hdeaddead, 8'd3};
        vecs[9]  = '{1'b0, 12'h3F0, 32'h00000000, 4'h0, 2'd1, 32'hdeaddead, 8'd4};
        vecs[10] = '{1'b0, 12'h000, 32'h00000000, 4'h0, 2'd0, 32'h00000000, 8'd4};
        vecs[11] = '{1'b1, 12'h004, 32'hCAFEF00D, 4'h3, 2'd0, 32'h00000000, 8'd4};
        vecs[12] = '{1'b0, 12'h004, 32'h00000000, 4'h0, 2'd0, 32'h1234F00D, 8'd4};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_valids", {28'd0, axi.awvalid, axi.wvalid, axi.arvalid, rsp_valid}, 32'd0);
        check("rst_readys", {30'd0, axi.bready, axi.rready}, 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_bus", {axi.awaddr, axi.araddr, 4'h0, axi.wstrb}, 32'd0);
        rst = 0;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Vector table against a zero-wait slave
        for (int i = 0; i < 13; i++) begin
            do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 0, 0);
            model_step(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, e_resp, e_rdata);
            if (!t_timeout) begin
                check($sformatf("vec%0d_resp", i), 32'(t_resp), 32'(vecs[i].exp_resp));
                check($sformatf("vec%0d_rdata", i), t_rdata, vecs[i].exp_rdata);
                check($sformatf("vec%0d_write", i), 32'(t_write), 32'(vecs[i].wr));
                check($sformatf("vec%0d_err", i), 32'(t_err), 32'(vecs[i].exp_err));
                check($sformatf("vec%0d_latency", i), 32'(t_lat), 32'd3);
                check($sformatf("vec%0d_bus_stable", i), 32'(t_addr_bad), 32'd0);
                @(negedge clk);
                check($sformatf("vec%0d_ready_back", i), {30'd0, cmd_ready, rsp_valid}, 32'd2);
            end
        end

        // Randomized traffic with random slave stalls and consumer backpressure
        for (int i = 0; i < 40; i++) begin
            bit          wr;
            int          region, word, hold;
            bit          spam;
            logic [11:0] a;
            logic [31:0] wd;
            logic [3:0]  ws;
            wr = 1'($urandom_range(0, 1));
            region = $urandom_range(0, 7);
            word = $urandom_range(0, 63);
            a = (region < 5) ? 12'(word * 4) : 12'((region - 4) * 256 + word * 4);
            wd = $urandom;
            ws = 4'($urandom_range(0, 15));
            hold = $urandom_range(0, 2);
            spam = 1'($urandom_range(0, 1));
            aw_stall = $urandom_range(0, 3); w_stall = $urandom_range(0, 3);
            b_stall = $urandom_range(0, 3); ar_stall = $urandom_range(0, 3);
            r_stall = $urandom_range(0, 3);
            do_txn(wr, a, wd, ws, hold, spam);
            model_step(wr, a, wd, ws, e_resp, e_rdata);
            if (!t_timeout) begin
                check($sformatf("rnd%0d_resp", i), 32'(t_resp), 32'(e_resp));
                check($sformatf("rnd%0d_rdata", i), t_rdata, e_rdata);
                check($sformatf("rnd%0d_write", i), 32'(t_write), 32'(wr));
                check($sformatf("rnd%0d_err", i), 32'(t_err), 32'(err_model));
                check($sformatf("rnd%0d_hold_stable", i), 32'(t_hold_bad), 32'd0);
                check($sformatf("rnd%0d_bus_stable", i), 32'(t_addr_bad), 32'd0);
            end
        end
        aw_stall = 0; w_stall = 0; b_stall = 0; ar_stall = 0; r_stall = 0;

        // awready held low 3 cycles while W completes at once
        aw_stall = 3;
        do_txn(1'b1, 12'h020, 32'h0BADBEEF, 4'hF, 0, 0);
        model_step(1'b1, 12'h020, 32'h0BADBEEF, 4'hF, e_resp, e_rdata);
        aw_stall = 0;
        check("awstall_aw_low_cycles", 32'(t_aw_low), 32'd3);
        check("awstall_w_cycles", 32'(t_w_cyc), 32'd1);
        check("awstall_addr_stable", 32'(t_addr_bad), 32'd0);
        @(negedge clk);
        check("awstall_single_rsp", 32'(rsp_valid), 32'd0);
        do_txn(1'b0, 12'h020, 32'h0, 4'h0, 0, 0);
        check("awstall_readback", t_rdata, 32'h0BADBEEF);

        // Consumer holds off 5 cycles while a new command is offered
        do_txn(1'b0, 12'h020, 32'h0, 4'h0, 5, 1);
        check("hold_payload_stable", 32'(t_hold_bad), 32'd0);
        check("hold_rdata", t_rdata, 32'h0BADBEEF);
        @(negedge clk);
        check("hold_no_spurious_txn", {30'd0, axi.awvalid, axi.arvalid}, 32'd0);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            do_txn(1'b0, 12'h100, 32'h0, 4'h0, 0, 0);
            model_step(1'b0, 12'h100, 32'h0, 4'h0, e_resp, e_rdata);
        end
        check("err_saturated", 32'(t_err), 32'h000000FF);
        check("err_rdata_slverr", t_rdata, 32'hdeaddead);
        check("err_resp_slverr", 32'(t_resp), 32'd2);

        // Reset while AW and W are both stalled
        aw_stall = 20; w_stall = 20;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h030; cmd_wdata = 32'h77777777; cmd_wstrb = 4'hF;
        @(posedge clk);
        #1 cmd_valid = 0;
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_pre_awvalid", {30'd0, axi.awvalid, axi.awready}, 32'd2);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_valids", {29'd0, axi.awvalid, axi.wvalid, cmd_ready}, 32'd0);
        check("mid_rst_err", 32'(err_count), 32'd0);
        rst = 0;
        err_model = 0;
        aw_stall = 0; w_stall = 0;
        @(negedge clk);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        do_txn(1'b0, 12'h100, 32'h0, 4'h0, 0, 0);
        model_step(1'b0, 12'h100, 32'h0, 4'h0, e_resp, e_rdata);
        check("after_rst_err", 32'(t_err), 32'(err_model));
        do_txn(1'b0, 12'h030, 32'h0, 4'h0, 0, 0);
        model_step(1'b0, 12'h030, 32'h0, 4'h0, e_resp, e_rdata);
        check("after_rst_abandoned_write", t_rdata, e_rdata);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
